// File: rtl/display_scan_ctrl_if.sv
// Digit-write and commit handshake between a digit producer and the
// display scan controller.
interface display_scan_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [4:0] wr_data;
    logic       commit;
    logic       commit_pending;

    // Producer side: issues writes and commit pulses
    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output commit,
        input  wr_ready,
        input  commit_pending
    );

    // Scan controller side
    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  commit,
        output wr_ready,
        output commit_pending
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed 4-digit 7-segment scan controller. Each digit slot is 16 scan
// ticks long: tick 0 is blanked dead time, then the digit is lit for
// bright_lat ticks, then it stays dark for the rest of the slot. New digit
// data is written into shadow registers. A commit copies the shadow set into
// the displayed set only at a frame boundary, so a frame never shows half of
// an update.
module display_scan_ctrl #(
    parameter int PRESCALE = 250
) (
    input  logic                      clk,
    input  logic                      rst_n,
    display_scan_ctrl_if.slave        bus,
    input  logic                      enable,
    input  logic [3:0]                brightness,
    output logic                      frame_start,
    output logic [7:0]                seg,
    output logic [3:0]                sel
);
    localparam int SLOT_TICKS = 16;
    localparam int PS_W       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_ON    = 2'd2;
    localparam logic [1:0] ST_OFF   = 2'd3;

    logic [1:0]      state_reg, state_next;
    logic [PS_W-1:0] prescaler_reg, prescaler_next;
    logic [3:0]      tick_cnt_reg, tick_cnt_next;
    logic [1:0]      digit_idx_reg, digit_idx_next;
    logic [3:0]      bright_lat_reg, bright_lat_next;
    logic            commit_pending_reg, commit_pending_next;
    logic            frame_start_reg, frame_start_next;
    logic [7:0]      seg_reg, seg_next;
    logic [3:0]      sel_reg, sel_next;

    logic            tick;
    logic            slot_end;
    logic            boundary;
    logic            copy_now;
    logic            wr_fire;
    logic [3:0][4:0] active_word;

    // Hex nibble to {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign tick     = (state_reg != ST_IDLE) && (prescaler_reg == PS_W'(PRESCALE - 1));
    assign slot_end = tick && (tick_cnt_reg == 4'(SLOT_TICKS - 1));
    assign wr_fire  = bus.wr_valid && !commit_pending_reg;
    // A pending commit lands when entering digit-0 blank, or at once while idle
    assign copy_now = commit_pending_reg && ((state_reg == ST_IDLE) || boundary);

    assign bus.wr_ready       = ~commit_pending_reg;
    assign bus.commit_pending = commit_pending_reg;
    assign frame_start        = frame_start_reg;
    assign seg                = seg_reg;
    assign sel                = sel_reg;

    // Per-digit shadow (write side) and active (display side) registers
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        logic [4:0] shadow_reg;
        logic [4:0] active_reg;

        // Shadow takes accepted writes; active reloads from shadow on commit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_reg <= 5'd0;
                active_reg <= 5'd0;
            end else begin
                if (wr_fire && (bus.wr_addr == 2'(gi))) begin
                    shadow_reg <= bus.wr_data;
                end
                if (copy_now) begin
                    active_reg <= shadow_reg;
                end
            end
        end

        assign active_word[gi] = active_reg;
    end

    // Scan sequencing, commit bookkeeping and next output values
    always_comb begin
        state_next          = state_reg;
        prescaler_next      = prescaler_reg;
        tick_cnt_next       = tick_cnt_reg;
        digit_idx_next      = digit_idx_reg;
        bright_lat_next     = bright_lat_reg;
        frame_start_next    = 1'b0;
        boundary            = 1'b0;

        if (!enable) begin
            state_next     = ST_IDLE;
            prescaler_next = '0;
            tick_cnt_next  = 4'd0;
            digit_idx_next = 2'd0;
        end else if (state_reg == ST_IDLE) begin
            state_next       = ST_BLANK;
            digit_idx_next   = 2'd0;
            bright_lat_next  = brightness;
            frame_start_next = 1'b1;
            boundary         = 1'b1;
        end else begin
            prescaler_next = tick ? '0 : prescaler_reg + 1'b1;
            if (tick) begin
                tick_cnt_next = tick_cnt_reg + 4'd1;
            end
            if (slot_end) begin
                // End of tick 15 always wins: start the next slot's dead time
                state_next      = ST_BLANK;
                digit_idx_next  = digit_idx_reg + 2'd1;
                bright_lat_next = brightness;
                if (digit_idx_reg == 2'd3) begin
                    frame_start_next = 1'b1;
                    boundary         = 1'b1;
                end
            end else if (tick) begin
                case (state_reg)
                    ST_BLANK: state_next = (bright_lat_reg != 4'd0) ? ST_ON : ST_OFF;
                    ST_ON:    if (tick_cnt_reg == bright_lat_reg) state_next = ST_OFF;
                    default:  state_next = state_reg;
                endcase
            end
        end

        if (copy_now) begin
            commit_pending_next = 1'b0;
        end else begin
            commit_pending_next = commit_pending_reg | bus.commit;
        end

        if (state_next == ST_ON) begin
            sel_next = 4'b0001 << digit_idx_next;
            seg_next = {active_word[digit_idx_next][4], hex_to_seg(active_word[digit_idx_next][3:0])};
        end else begin
            sel_next = 4'b0000;
            seg_next = 8'h00;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= ST_IDLE;
            prescaler_reg      <= '0;
            tick_cnt_reg       <= 4'd0;
            digit_idx_reg      <= 2'd0;
            bright_lat_reg     <= 4'd0;
            commit_pending_reg <= 1'b0;
            frame_start_reg    <= 1'b0;
            seg_reg            <= 8'h00;
            sel_reg            <= 4'b0000;
        end else begin
            state_reg          <= state_next;
            prescaler_reg      <= prescaler_next;
            tick_cnt_reg       <= tick_cnt_next;
            digit_idx_reg      <= digit_idx_next;
            bright_lat_reg     <= bright_lat_next;
            commit_pending_reg <= commit_pending_next;
            frame_start_reg    <= frame_start_next;
            seg_reg            <= seg_next;
            sel_reg            <= sel_next;
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl. A time-based reference model predicts every
// output each cycle into a queue, and a monitor compares the DUT against it.
module tb_display_scan_ctrl;
    localparam int P     = 4;
    localparam int SLOT  = 16 * P;
    localparam int FRAME = 64 * P;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [3:0] brightness;
    logic       frame_start;
    logic [7:0] seg;
    logic [3:0] sel;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(.PRESCALE(P)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .enable      (enable),
        .brightness  (brightness),
        .frame_start (frame_start),
        .seg         (seg),
        .sel         (sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] seg;
        logic       fs;
        logic       wr_ready;
        logic       cp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [6:0] seg_lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endfunction

    // Reference model: position in the frame is just elapsed cycles since
    // scanning started, so slot, dead time and lit window follow from arithmetic.
    bit         m_on = 0;
    bit         m_scan;
    int         m_cyc;
    int         m_blat;
    logic [4:0] m_shadow [4];
    logic [4:0] m_active [4];
    bit         m_pend;
    bit         m_wr_acc;
    bit         m_was_idle;
    bit         m_boundary;
    bit         m_lit;
    int         m_slot;
    int         m_pos;
    exp_t       e_mod;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_scan = 0; m_cyc = 0; m_blat = 0; m_pend = 0; m_wr_acc = 0;
            for (int i = 0; i < 4; i++) begin
                m_shadow[i] = 5'd0;
                m_active[i] = 5'd0;
            end
        end else if (m_on) begin
            m_was_idle = !m_scan;
            m_boundary = 0;
            m_wr_acc   = bus.wr_valid && !m_pend;
            if (m_wr_acc) begin
                m_shadow[bus.wr_addr] = bus.wr_data;
                $display("write  digit %0d <= %02h at %0t", bus.wr_addr, bus.wr_data, $time);
            end
            if (!enable) begin
                m_scan = 0;
                m_cyc  = 0;
            end else if (!m_scan) begin
                m_scan     = 1;
                m_cyc      = 0;
                m_blat     = brightness;
                m_boundary = 1;
            end else begin
                m_cyc = (m_cyc + 1) % FRAME;
                if (m_cyc % SLOT == 0) m_blat = brightness;
                if (m_cyc == 0) m_boundary = 1;
            end
            if (m_pend && (m_was_idle || m_boundary)) begin
                for (int i = 0; i < 4; i++) m_active[i] = m_shadow[i];
                m_pend = 0;
                $display("commit applied %02h %02h %02h %02h at %0t",
                         m_active[3], m_active[2], m_active[1], m_active[0], $time);
            end else if (bus.commit) begin
                m_pend = 1;
            end
            m_slot = m_cyc / SLOT;
            m_pos  = m_cyc % SLOT;
            m_lit  = m_scan && (m_pos >= P) && (m_pos < P * (1 + m_blat));
            e_mod.sel      = m_lit ? 4'(1 << m_slot) : 4'b0000;
            e_mod.seg      = m_lit ? {m_active[m_slot][4], seg_lut[m_active[m_slot][3:0]]} : 8'h00;
            e_mod.fs       = m_boundary;
            e_mod.wr_ready = !m_pend;
            e_mod.cp       = m_pend;
            exp_q.push_back(e_mod);
        end
    end

    // Monitor: outputs are presented every cycle, compare on the falling edge
    exp_t e_mon;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            check("sel", 32'(sel), 32'(e_mon.sel));
            check("seg", 32'(seg), 32'(e_mon.seg));
            check("frame_start", 32'(frame_start), 32'(e_mon.fs));
            check("wr_ready", 32'(bus.wr_ready), 32'(e_mon.wr_ready));
            check("commit_pending", 32'(bus.commit_pending), 32'(e_mon.cp));
        end
    end

    task automatic do_write(input logic [1:0] a, input logic [4:0] d);
        int n;
        @(negedge clk);
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.wr_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_wr_acc && n < 2000);
        n_checks++;
        if (m_wr_acc) n_pass++;
        else $display("FAIL write_timeout: got no accept, expected accept within 2000 cycles");
        bus.wr_valid = 1'b0;
    endtask

    task automatic pulse_commit();
        @(negedge clk);
        bus.commit = 1'b1;
        @(negedge clk);
        bus.commit = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sel(input logic [3:0] s);
        int n;
        n = 0;
        while (sel !== s && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (sel === s) n_pass++;
        else $display("FAIL sel_timeout: got %b, expected %b within 2000 cycles", sel, s);
    endtask

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        brightness = 4'd0;
        bus.wr_valid = 1'b0;
        bus.wr_addr = 2'd0;
        bus.wr_data = 5'd0;
        bus.commit = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sel), 32'h0);
        check("rst_seg", 32'(seg), 32'h0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'h1);
        check("rst_commit_pending", 32'(bus.commit_pending), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        rst_n = 1'b1;
        m_on  = 1;

        // Digits "1234", commit while idle, full brightness scan
        do_write(2'd3, 5'h01);
        do_write(2'd2, 5'h02);
        do_write(2'd1, 5'h03);
        do_write(2'd0, 5'h04);
        pulse_commit();
        run(2);
        brightness = 4'd15;
        enable = 1'b1;
        run(600);

        // Mid-frame update "5678" with dp on digit 2, second write stalls
        wait_sel(4'b0010);
        do_write(2'd3, 5'h05);
        do_write(2'd2, 5'h16);
        do_write(2'd1, 5'h07);
        do_write(2'd0, 5'h08);
        pulse_commit();
        do_write(2'd1, 5'h09);
        run(300);

        // Write and commit in the same cycle, then a stalled follow-up write
        wait_sel(4'b0100);
        @(negedge clk);
        bus.wr_addr = 2'd3;
        bus.wr_data = 5'h0F;
        bus.wr_valid = 1'b1;
        bus.commit = 1'b1;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.commit = 1'b0;
        do_write(2'd0, 5'h1A);
        run(300);

        // Brightness edge cases, including a change in the middle of a slot
        brightness = 4'd0;
        run(300);
        brightness = 4'd1;
        run(300);
        brightness = 4'd15;
        wait_sel(4'b0001);
        run(10);
        brightness = 4'd3;
        run(300);

        // Enable drop mid digit-2 slot, then restart
        wait_sel(4'b0100);
        run(5);
        enable = 1'b0;
        run(8);
        enable = 1'b1;
        run(300);

        // Randomised traffic
        for (int c = 0; c < 15000; c++) begin
            @(negedge clk);
            bus.commit = 1'b0;
            if (bus.wr_valid && m_wr_acc) bus.wr_valid = 1'b0;
            if (!bus.wr_valid && $urandom_range(0, 29) == 0) begin
                bus.wr_addr  = 2'($urandom_range(0, 3));
                bus.wr_data  = 5'($urandom_range(0, 31));
                bus.wr_valid = 1'b1;
            end
            if ($urandom_range(0, 149) == 0) bus.commit = 1'b1;
            if ($urandom_range(0, 299) == 0) brightness = 4'($urandom_range(0, 15));
            if (enable && $urandom_range(0, 1499) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.commit = 1'b0;

        // Asynchronous reset while a digit is lit
        enable = 1'b1;
        brightness = 4'd15;
        run(300);
        wait_sel(4'b1000);
        m_on = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sel", 32'(sel), 32'h0);
        check("async_rst_seg", 32'(seg), 32'h0);
        check("async_rst_wr_ready", 32'(bus.wr_ready), 32'h1);
        check("async_rst_commit_pending", 32'(bus.commit_pending), 32'h0);
        check("async_rst_frame_start", 32'(frame_start), 32'h0);
        run(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
